// File: rtl/md_unit_if.sv
`timescale 1ns/1ps
// Issue/result bundle between the EX stage and the multiply/divide unit.
interface md_unit_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] in_1;
    logic [31:0] in_2;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (output start, op, in_1, in_2, flush, input busy, done, hi, lo);
    modport slave  (input start, op, in_1, in_2, flush, output busy, done, hi, lo);
endinterface

// File: rtl/md_unit.sv
`timescale 1ns/1ps
// Iterative MULT/MULTU/DIV/DIVU with HI/LO; 34-cycle issue-to-done (2 on div-by-zero), MTHI/MTLO 1 cycle.
// No backpressure: start is ignored while busy; flush aborts and suppresses the HI/LO write.
module md_unit #(
    parameter logic [31:0] DIV0_LO = 32'hFFFFFFFF
) (
    input  logic     clk,
    input  logic     reset_n,
    md_unit_if.slave bus
);

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] RUN  = 2'b01;
    localparam logic [1:0] FIN  = 2'b10;

    logic [1:0]  state;
    logic [4:0]  cnt;
    logic [64:0] acc;
    logic [31:0] mcand;
    logic        is_div;
    logic        neg_res;
    logic        neg_rem;
    logic        div0;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        done_q;

    logic        op_div;
    logic        op_sgn;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [32:0] mul_sum;
    logic [32:0] div_trial;
    logic [64:0] acc_step;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    assign op_div = bus.op[1];
    assign op_sgn = ~bus.op[0];
    assign a_mag  = (op_sgn && bus.in_1[31]) ? (~bus.in_1 + 32'd1) : bus.in_1;
    assign b_mag  = (op_sgn && bus.in_2[31]) ? (~bus.in_2 + 32'd1) : bus.in_2;

    // acc holds {carry, acc, multiplier} for multiply and {rem[32:0], quotient} for divide
    always_comb begin
        mul_sum   = {1'b0, acc[63:32]} + {1'b0, mcand};
        div_trial = acc[63:31] - {1'b0, mcand};
        acc_step  = acc;
        if (!is_div) begin
            acc_step = acc[0] ? {1'b0, mul_sum, acc[31:1]} : {1'b0, acc[64:1]};
        end else begin
            acc_step = div_trial[32] ? {acc[63:0], 1'b0} : {div_trial, acc[30:0], 1'b1};
        end
    end

    assign prod_fix = neg_res ? (~acc[63:0] + 64'd1)  : acc[63:0];
    assign quo_fix  = neg_res ? (~acc[31:0] + 32'd1)  : acc[31:0];
    assign rem_fix  = neg_rem ? (~acc[63:32] + 32'd1) : acc[63:32];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            cnt     <= 5'd0;
            acc     <= 65'd0;
            mcand   <= 32'd0;
            is_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            div0    <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.flush) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.start) begin
                            if (bus.op == 3'b100) begin
                                hi_q <= bus.in_1;
                            end else if (bus.op == 3'b101) begin
                                lo_q <= bus.in_1;
                            end else if (!bus.op[2]) begin
                                is_div  <= op_div;
                                neg_res <= op_sgn && (bus.in_1[31] ^ bus.in_2[31]);
                                neg_rem <= op_sgn && bus.in_1[31];
                                mcand   <= op_div ? b_mag : a_mag;
                                cnt     <= 5'd31;
                                if (op_div && (bus.in_2 == 32'd0)) begin
                                    // HI must return the dividend exactly as issued
                                    div0  <= 1'b1;
                                    acc   <= {33'd0, bus.in_1};
                                    state <= FIN;
                                end else begin
                                    div0  <= 1'b0;
                                    acc   <= {33'd0, op_div ? a_mag : b_mag};
                                    state <= RUN;
                                end
                            end
                        end
                    end
                    RUN: begin
                        acc <= acc_step;
                        cnt <= cnt - 5'd1;
                        if (cnt == 5'd0) begin
                            state <= FIN;
                        end
                    end
                    FIN: begin
                        if (div0) begin
                            hi_q <= acc[31:0];
                            lo_q <= DIV0_LO;
                        end else if (is_div) begin
                            hi_q <= rem_fix;
                            lo_q <= quo_fix;
                        end else begin
                            hi_q <= prod_fix[63:32];
                            lo_q <= prod_fix[31:0];
                        end
                        done_q <= 1'b1;
                        state  <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.busy = (state != IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
`timescale 1ns/1ps
// Bench for md_unit: directed vector table, randomized ops against a 64-bit arithmetic model,
// and hand sequences for MTHI/MTLO, flush, reserved op and asynchronous reset.
module tb_md_unit;

    logic clk;
    logic reset_n;
    int   vec_cnt;
    int   miscompares;

    md_unit_if bus ();

    md_unit #(.DIV0_LO(32'hFFFFFFFF)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eh;
        logic [31:0] el;
        int          lat;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic; returns {hi, lo}
    function automatic logic [63:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      sq;
        longint      sr;
        logic [63:0] ua;
        logic [63:0] ub;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        r  = 64'd0;
        case (op)
            3'b000: r = sa * sb;
            3'b001: r = ua * ub;
            3'b010: begin
                if (b == 32'd0) r = {a, 32'hFFFFFFFF};
                else begin
                    sq = sa / sb;
                    sr = sa % sb;
                    r  = {sr[31:0], sq[31:0]};
                end
            end
            3'b011: begin
                if (b == 32'd0) r = {a, 32'hFFFFFFFF};
                else r = {32'(ua % ub), 32'(ua / ub)};
            end
            default: r = 64'd0;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] pick();
        logic [31:0] corner [5];
        corner[0] = 32'd0;
        corner[1] = 32'd1;
        corner[2] = 32'hFFFFFFFF;
        corner[3] = 32'h80000000;
        corner[4] = 32'h7FFFFFFF;
        case ($urandom_range(0, 3))
            0:       return 32'($urandom_range(0, 20));
            1:       return corner[$urandom_range(0, 4)];
            default: return $urandom;
        endcase
    endfunction

    // Issues one mul/div and follows it to done; optionally pokes an MTHI at RUN cycle inj
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el, input int lat,
                          input int inj, input string nm);
        int k;
        int bad;
        bit seen;
        @(negedge clk);
        bus.start = 1'b1; bus.op = o; bus.in_1 = a; bus.in_2 = b;
        @(negedge clk);
        bus.start = 1'b0;
        k = 1; bad = 0; seen = 1'b0;
        while (!seen && k <= 40) begin
            if (bus.done === 1'b1) seen = 1'b1;
            else begin
                if (bus.busy !== 1'b1) bad++;
                @(negedge clk);
                k++;
                if (k == inj) begin
                    bus.start = 1'b1; bus.op = 3'b100; bus.in_1 = 32'hDEADBEEF;
                end else begin
                    bus.start = 1'b0;
                end
            end
        end
        bus.start = 1'b0;
        chk({nm, " done_cycle"}, 64'(seen ? k : 0), 64'(lat));
        chk({nm, " busy_gap"}, 64'(bad), 64'(0));
        chk({nm, " busy_at_done"}, 64'(bus.busy), 64'(0));
        chk({nm, " hi"}, 64'(bus.hi), 64'(eh));
        chk({nm, " lo"}, 64'(bus.lo), 64'(el));
        @(negedge clk);
        chk({nm, " done_pulse_len"}, 64'(bus.done), 64'(0));
    endtask

    task automatic issue_one(input logic [2:0] o, input logic [31:0] a, input logic f);
        @(negedge clk);
        bus.start = 1'b1; bus.op = o; bus.in_1 = a; bus.in_2 = 32'd0; bus.flush = f;
        @(negedge clk);
        bus.start = 1'b0; bus.flush = 1'b0;
    endtask

    task automatic no_done_for(input int n, input string nm);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen = 1'b1;
        end
        chk({nm, " no_done"}, 64'(seen), 64'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl [12];
        logic [63:0] exp;
        logic [2:0]  o;
        logic [31:0] a;
        logic [31:0] b;

        tbl[0]  = '{3'b000, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 34};
        tbl[1]  = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 34};
        tbl[2]  = '{3'b011, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 34};
        tbl[3]  = '{3'b010, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 34};
        tbl[4]  = '{3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 34};
        tbl[5]  = '{3'b010, 32'd5,        32'd0,        32'h00000005, 32'hFFFFFFFF, 2};
        tbl[6]  = '{3'b011, 32'd9,        32'd0,        32'h00000009, 32'hFFFFFFFF, 2};
        tbl[7]  = '{3'b010, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 2};
        tbl[8]  = '{3'b000, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 34};
        tbl[9]  = '{3'b011, 32'hFFFFFFFF, 32'd1,        32'h00000000, 32'hFFFFFFFF, 34};
        tbl[10] = '{3'b010, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 34};
        tbl[11] = '{3'b001, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 34};

        vec_cnt = 0;
        miscompares = 0;
        reset_n = 1'b0;
        bus.start = 1'b0; bus.op = 3'b000; bus.in_1 = 32'd0; bus.in_2 = 32'd0; bus.flush = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("reset busy", 64'(bus.busy), 64'(0));
        chk("reset done", 64'(bus.done), 64'(0));
        chk("reset hi", 64'(bus.hi), 64'(0));
        chk("reset lo", 64'(bus.lo), 64'(0));

        for (int i = 0; i < 12; i++) begin
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].eh, tbl[i].el, tbl[i].lat, 0,
                   $sformatf("vec%0d", i));
        end

        // MTHI then MTLO on consecutive cycles
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'b100; bus.in_1 = 32'h12345678;
        @(negedge clk);
        chk("mthi hi", 64'(bus.hi), 64'h12345678);
        chk("mthi busy", 64'(bus.busy), 64'(0));
        chk("mthi done", 64'(bus.done), 64'(0));
        bus.op = 3'b101; bus.in_1 = 32'hCAFEF00D;
        @(negedge clk);
        bus.start = 1'b0;
        chk("mtlo lo", 64'(bus.lo), 64'hCAFEF00D);
        chk("mtlo hi_kept", 64'(bus.hi), 64'h12345678);
        chk("mtlo busy", 64'(bus.busy), 64'(0));
        chk("mtlo done", 64'(bus.done), 64'(0));

        // Reserved op leaves everything alone
        issue_one(3'b110, 32'h0BADF00D, 1'b0);
        chk("rsvd busy", 64'(bus.busy), 64'(0));
        chk("rsvd hi", 64'(bus.hi), 64'h12345678);
        chk("rsvd lo", 64'(bus.lo), 64'hCAFEF00D);

        // MTHI issued mid-run must be dropped
        run_op(3'b000, 32'd3, 32'd4, 32'd0, 32'd12, 34, 5, "mthi_while_busy");

        // Flush at RUN cycle 10
        issue_one(3'b100, 32'hAAAAAAAA, 1'b0);
        issue_one(3'b101, 32'h55555555, 1'b0);
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'b000; bus.in_1 = 32'd3; bus.in_2 = 32'd4;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        chk("flush busy_next", 64'(bus.busy), 64'(0));
        no_done_for(40, "flush_run");
        chk("flush hi", 64'(bus.hi), 64'hAAAAAAAA);
        chk("flush lo", 64'(bus.lo), 64'h55555555);

        // start alongside flush is ignored
        issue_one(3'b000, 32'd3, 1'b1);
        chk("start_flush busy", 64'(bus.busy), 64'(0));
        issue_one(3'b100, 32'h00000001, 1'b1);
        chk("mthi_flush hi", 64'(bus.hi), 64'hAAAAAAAA);

        // Flush while in FIN (div-by-zero reaches FIN one cycle after issue)
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'b010; bus.in_1 = 32'd5; bus.in_2 = 32'd0;
        @(negedge clk);
        bus.start = 1'b0;
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        chk("fin_flush busy", 64'(bus.busy), 64'(0));
        no_done_for(3, "fin_flush");
        chk("fin_flush hi", 64'(bus.hi), 64'hAAAAAAAA);
        chk("fin_flush lo", 64'(bus.lo), 64'h55555555);

        // Asynchronous reset at RUN cycle 5
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'b000; bus.in_1 = 32'd3; bus.in_2 = 32'd4;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("arst hi", 64'(bus.hi), 64'(0));
        chk("arst lo", 64'(bus.lo), 64'(0));
        chk("arst busy", 64'(bus.busy), 64'(0));
        @(negedge clk);
        reset_n = 1'b1;
        no_done_for(40, "arst");
        run_op(3'b000, 32'd3, 32'd4, 32'd0, 32'd12, 34, 0, "after_arst");

        // Randomized ops against the arithmetic model
        for (int i = 0; i < 30; i++) begin
            o = 3'($urandom_range(0, 3));
            a = pick();
            b = pick();
            exp = ref_md(o, a, b);
            run_op(o, a, b, exp[63:32], exp[31:0], (o[1] && b == 32'd0) ? 2 : 34, 0,
                   $sformatf("rnd%0d op%0d %h %h", i, o, a, b));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
        $finish;
    end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
Iterative multiply/divide unit with architectural HI/LO registers, sitting in the EX stage beside the integer ALU.
- Fed by the ID/EX pipeline register with the same forwarded operands the ALU receives.
- Executes MULT/MULTU/DIV/DIVU over multiple cycles; MTHI/MTLO complete in a single cycle.
- Its busy output drives the hazard unit, which stalls MFHI/MFLO and any new mul/div op until the result is ready.

Parameters:
DIV0_LO, 32'hFFFFFFFF, value written to LO on divide-by-zero.

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous, active-low reset
start  input  1  issue pulse from EX; sampled only when busy=0
op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x reserved (ignored)
in_1  input  32  rs operand: multiplicand / dividend / MTHI/MTLO data
in_2  input  32  rt operand: multiplier / divisor
flush  input  1  pipeline flush; aborts any in-flight operation
busy  output  1  operation in flight (state != IDLE)
done  output  1  one-cycle pulse; HI/LO have just been updated by a mul/div
hi  output  32  HI register
lo  output  32  LO register

Behaviour:
- Reset (reset_n=0, asynchronous):
  - state=IDLE; hi=lo=0; busy=0; done=0; all internal registers cleared.
  - Reset mid-operation discards all partial state.
- States: IDLE, RUN, FIN.
- IDLE:
  - start=1, op=MTHI/MTLO: hi (or lo) <= in_1 at that edge; stays in IDLE; done is not asserted.
  - start=1, op=mul/div: latches operands and op.
    - Loads magnitudes when signed (MULT/DIV); raw values when unsigned.
    - Records the result-sign flags.
    - Sets cnt=31 and goes to RUN.
  - DIV/DIVU with in_2=0 goes directly to FIN with a div-by-zero flag set.
  - Reserved op: no effect.
- RUN: one iteration per cycle; cnt decrements; moves to FIN after the cnt=0 iteration, i.e. after 32 RUN cycles.
  - Multiply: shift-add on a 65-bit {carry, acc, multiplier} register. If the multiplier LSB is 1, add the multiplicand to the upper 33 bits, then shift right by 1.
  - Divide: restoring on {rem[32:0], quotient}. Shift left by 1, trial-subtract the divisor. If the result is non-negative, keep it and set quotient LSB=1.
- FIN: one cycle, then IDLE. At the edge leaving FIN, hi/lo are written and done <= 1 for exactly the next cycle.
  - Signed multiply: 64-bit product is two's-complement negated if the operand signs differ.
  - Signed divide: quotient negated if the signs differ; remainder takes the dividend's sign.
  - Fixed case: -2^31 / -1 gives lo=32'h80000000, hi=0.
  - Div-by-zero: lo=DIV0_LO, hi=in_1 as latched (unsigned or signed, unmodified).
- Latency, with start sampled at the end of cycle N:
  - Normal mul/div: busy=1 in cycles N+1..N+33; hi/lo new and done=1 in cycle N+34; busy=0 in N+34.
  - Div-by-zero: busy=1 in N+1; done=1 and result visible in N+2.
- start while busy=1 is ignored (no effect on the operation, operands or HI/LO).
- flush=1 in any cycle:
  - state <= IDLE at the next edge; hi/lo are unchanged; done is not asserted.
  - start in the same cycle as flush is ignored.
  - flush in FIN also aborts, so the HI/LO write is suppressed.
- hi/lo are direct register outputs with no bypass; MFHI/MFLO read them when busy=0.
- All arithmetic is mod 2^32 per half; no overflow or exception outputs.

Test Plan:
- Reset then MULT in_1=32'hFFFFFFFD (-3), in_2=7 -> busy for 33 cycles; done pulse in cycle N+34; hi=32'hFFFFFFFF, lo=32'hFFFFFFEB.
- MULTU in_1=in_2=32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001; then DIVU 100/7 -> lo=32'h0000000E, hi=32'h00000002.
- DIV -7/2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF; DIV 32'h80000000 / 32'hFFFFFFFF -> lo=32'h80000000, hi=0.
- DIV 5/0 -> done in cycle N+2; lo=32'hFFFFFFFF, hi=5; DIVU 9/0 identical in timing.
- MTHI 32'h12345678 then MTLO 32'hCAFEF00D in consecutive cycles -> hi/lo update on those edges; busy and done stay 0; MTHI issued while busy is ignored.
- MULT 3*4 with flush at RUN cycle 10 -> busy=0 next cycle, hi/lo keep prior values, no done pulse; reset_n low at RUN cycle 5 of another op -> hi=lo=0 immediately.
